bus_loader: RTL and testbench

BUS_LOADER -- requirements
Module: bus_loader

---
 rtl/zx48_pkg.sv | 25 ++
 rtl/bus_loader.sv | 149 ++++++++++++++
 tb/tb_bus_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx48_pkg.sv
// zx48_pkg: encodings and constants shared by the ZX48 bus-side blocks
// (loader FSM states, DivMMC control port, cycle lengths).
package zx48_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAGE    = 3'd1,
    S_FETCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
    S_UNPAGE  = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  localparam logic [15:0] DIVMMC_PORT   = 16'h00E3;
  localparam logic [7:0]  DIVMMC_CONMEM = 8'h80;

  // PAGE/UNPAGE: one cycle with IO strobes low, one cycle released.
  localparam int PAGE_CYCLES = 2;

  function automatic logic [7:0] divmmc_page_byte(input logic [3:0] pg);
    return DIVMMC_CONMEM | {4'h0, pg};
  endfunction

endpackage

// File: rtl/bus_loader.sv
// bus_loader: turns a byte stream into Z80-style memory write cycles at
// consecutive addresses. Optional DivMMC page-in/out: BUS_LOADER_DIVMMC_PAGE_EN.
module bus_loader
  import zx48_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [15:0] len,
  input  logic [3:0]  page,
  input  logic [7:0]  sd,
  input  logic        svalid,
  output logic        sready,
  output logic        mreq,
  output logic        iorq,
  output logic        wr,
  output logic        rd,
  output logic        m1,
  output logic        rfsh,
  output logic [15:0] a,
  output logic [7:0]  d,
  output logic        busy,
  output logic        done
);

  localparam logic PH_LAST = 1'(PAGE_CYCLES - 1);

  state_t      state, state_n;
  logic        ph, ph_n;
  logic [15:0] ptr;
  logic [15:0] cnt;
  logic [15:0] cnt_dec;
  logic        mem_phase_n;
  logic        io_phase_n;

  assign cnt_dec = cnt - 16'd1;

  assign rd   = 1'b1;
  assign m1   = 1'b1;
  assign rfsh = 1'b1;

  always_comb begin
    state_n = state;
    ph_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef BUS_LOADER_DIVMMC_PAGE_EN
          state_n = S_PAGE;
`else
          state_n = (len != 16'd0) ? S_FETCH : S_FIN;
`endif
        end
      end
      S_PAGE: begin
        if (ph == PH_LAST) state_n = (cnt != 16'd0) ? S_FETCH : S_UNPAGE;
        else               ph_n    = ph + 1'b1;
      end
      S_FETCH: begin
        if (svalid) state_n = S_WRITE;
      end
      S_WRITE: begin
        state_n = S_RELEASE;
      end
      S_RELEASE: begin
        if (cnt_dec != 16'd0) begin
          state_n = S_FETCH;
        end else begin
`ifdef BUS_LOADER_DIVMMC_PAGE_EN
          state_n = S_UNPAGE;
`else
          state_n = S_FIN;
`endif
        end
      end
      S_UNPAGE: begin
        if (ph == PH_LAST) state_n = S_FIN;
        else               ph_n    = ph + 1'b1;
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so the bus never sees decode glitches.
  always_comb begin
    mem_phase_n = (state_n == S_WRITE);
`ifdef BUS_LOADER_DIVMMC_PAGE_EN
    io_phase_n  = ((state_n == S_PAGE) || (state_n == S_UNPAGE)) && (ph_n == 1'b0);
`else
    io_phase_n  = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      ph     <= 1'b0;
      ptr    <= 16'h0000;
      cnt    <= 16'h0000;
      a      <= 16'h0000;
      d      <= 8'h00;
      mreq   <= 1'b1;
      iorq   <= 1'b1;
      wr     <= 1'b1;
      sready <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ce) begin
      state  <= state_n;
      ph     <= ph_n;
      mreq   <= ~mem_phase_n;
      iorq   <= ~io_phase_n;
      wr     <= ~(mem_phase_n | io_phase_n);
      sready <= (state_n == S_FETCH);
      busy   <= (state_n != S_IDLE);
      done   <= (state_n == S_FIN);

      if ((state == S_IDLE) && start) begin
        ptr <= addr;
        cnt <= len;
      end
      if ((state == S_FETCH) && svalid) begin
        a <= ptr;
        d <= sd;
      end
      // Address wraps naturally at 16 bits.
      if (state == S_RELEASE) begin
        ptr <= ptr + 16'd1;
        cnt <= cnt_dec;
      end
      if ((state_n == S_PAGE) && (state != S_PAGE)) begin
        a <= DIVMMC_PORT;
        d <= divmmc_page_byte(page);
      end
      if ((state_n == S_UNPAGE) && (state != S_UNPAGE)) begin
        a <= DIVMMC_PORT;
        d <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_bus_loader.sv
// tb_bus_loader: randomized bench for bus_loader, checked against a
// transfer-level model (expected write list, done timing, bus invariants).
module tb_bus_loader;

  logic        clock, reset, ce, start;
  logic [15:0] addr, len;
  logic [3:0]  page;
  logic [7:0]  sd;
  logic        svalid;
  logic        sready, mreq, iorq, wr, rd, m1, rfsh;
  logic [15:0] a;
  logic [7:0]  d;
  logic        busy, done;

`ifdef BUS_LOADER_DIVMMC_PAGE_EN
  localparam int PAGE_OVH = 2;
  localparam int IO_EXP   = 2;
`else
  localparam int PAGE_OVH = 0;
  localparam int IO_EXP   = 0;
`endif

  bus_loader dut (
    .clock(clock), .reset(reset), .ce(ce), .start(start),
    .addr(addr), .len(len), .page(page), .sd(sd), .svalid(svalid),
    .sready(sready), .mreq(mreq), .iorq(iorq), .wr(wr), .rd(rd),
    .m1(m1), .rfsh(rfsh), .a(a), .d(d), .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [7:0]  src_q[$];
  logic [7:0]  exp_b[$];
  logic [15:0] mw_a[$];
  logic [7:0]  mw_d[$];
  int          mw_e[$];
  logic [15:0] io_a[$];
  logic [7:0]  io_d[$];
  int          ev_q[$];
  int          done_q[$];
  int          ce_idx, consumed, viol, stall_bad, stall_left, stall_at, stall_hits;
  bit          stall_armed, ce_rand, gap_rand, start_noise, timed_out, prev_mreq_low;
  int          checks, errors;

  task automatic clear_log();
    mw_a.delete(); mw_d.delete(); mw_e.delete();
    io_a.delete(); io_d.delete(); ev_q.delete(); done_q.delete();
    ce_idx = 0; consumed = 0; viol = 0; stall_bad = 0; stall_hits = 0;
    stall_left = 0; prev_mreq_low = 1'b0; timed_out = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
  endtask

  // One clock: observe what the last ce edge produced, then drive new inputs.
  task automatic cycle();
    bit hs, was_ce, was_stall;
    hs        = ce && sready && svalid;
    was_ce    = ce;
    was_stall = (stall_left > 0);
    @(posedge clock); #1;
    if (was_ce) begin
      ce_idx++;
      if (hs) begin
        void'(src_q.pop_front());
        consumed++;
      end
      if (!mreq && !wr) begin
        mw_a.push_back(a); mw_d.push_back(d); mw_e.push_back(ce_idx); ev_q.push_back(1);
      end
      if (!iorq && !wr) begin
        io_a.push_back(a); io_d.push_back(d); ev_q.push_back(0);
      end
      if (done) done_q.push_back(ce_idx);
      if (rd !== 1'b1 || m1 !== 1'b1 || rfsh !== 1'b1) viol++;
      if (!mreq && prev_mreq_low) viol++;
      if (!mreq && !iorq) viol++;
      if (sready && !busy) viol++;
      if (!mreq && sready) viol++;
`ifndef BUS_LOADER_DIVMMC_PAGE_EN
      if (iorq !== 1'b1) viol++;
`endif
      prev_mreq_low = !mreq;
      if (was_stall) begin
        stall_hits++;
        if (sready !== 1'b1 || mreq !== 1'b1 || wr !== 1'b1) stall_bad++;
        stall_left--;
      end
      if (stall_armed && sready && consumed == stall_at) begin
        stall_left  = 5;
        stall_armed = 1'b0;
      end
    end
    ce     = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    start  = (start_noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    addr   = 16'($urandom);
    len    = 16'($urandom_range(0, 8));
    page   = 4'($urandom);
    svalid = (src_q.size() > 0) && (stall_left == 0) && (!gap_rand || $urandom_range(0, 2) != 0);
    sd     = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
  endtask

  task automatic launch(input logic [15:0] a0, input logic [15:0] n,
                        input logic [3:0] pg, input int budget);
    clear_log();
    exp_b  = src_q;
    addr   = a0; len = n; page = pg;
    start  = 1'b1; ce = 1'b1;
    svalid = (src_q.size() > 0);
    sd     = (src_q.size() > 0) ? src_q[0] : 8'h00;
    cycle();
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done_q.size() > 0 && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ce = 1'b0; start = 1'b1; addr = 16'($urandom); len = 16'd5;
    page = 4'($urandom); svalid = 1'b1; sd = 8'($urandom);
    repeat (3) @(posedge clock);
    ce = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({sready, mreq, iorq, wr, rd, m1, rfsh, busy, done} !== 9'b0_1111_11_00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {sready, mreq, iorq, wr, rd, m1, rfsh, busy, done}, 9'b011111100);
    end
    checks++;
    if (a !== 16'h0000) begin errors++; $display("FAIL reset_a: got %h expected 0000", a); end
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected 00", d); end
    start = 1'b0; svalid = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    ce_rand = 0; gap_rand = 0; start_noise = 0;
    src_q = '{8'hAA, 8'hBB, 8'hCC};
    launch(16'h4000, 16'd3, 4'h0, 60);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: got 1 expected 0"); end
    checks++;
    if (mw_a.size() !== 3) begin errors++; $display("FAIL basic_nwrites: got %0d expected 3", mw_a.size()); end
    for (int i = 0; i < mw_a.size() && i < 3; i++) begin
      checks++;
      if (mw_a[i] !== 16'(16'h4000 + i) || mw_d[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL basic_write[%0d]: got %h/%h expected %h/%h", i, mw_a[i], mw_d[i], 16'(16'h4000 + i), exp_b[i]);
      end
      checks++;
      if (mw_e[i] !== 2 + PAGE_OVH + 3 * i) begin
        errors++;
        $display("FAIL basic_write_cycle[%0d]: got %0d expected %0d", i, mw_e[i], 2 + PAGE_OVH + 3 * i);
      end
    end
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL basic_ndone: got %0d expected 1", done_q.size()); end
    if (done_q.size() > 0) begin
      checks++;
      if (done_q[0] !== 10 + 2 * PAGE_OVH) begin
        errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_q[0], 10 + 2 * PAGE_OVH);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL basic_invariants: got %0d expected 0", viol); end
    checks++;
    if (io_a.size() !== IO_EXP) begin errors++; $display("FAIL basic_io: got %0d expected %0d", io_a.size(), IO_EXP); end
  endtask

  task automatic test_wrap();
    fill(2);
    launch(16'hFFFF, 16'd2, 4'h0, 60);
    checks++;
    if (mw_a.size() !== 2) begin errors++; $display("FAIL wrap_nwrites: got %0d expected 2", mw_a.size()); end
    if (mw_a.size() == 2) begin
      checks++;
      if (mw_a[0] !== 16'hFFFF || mw_d[0] !== exp_b[0]) begin
        errors++; $display("FAIL wrap_first: got %h/%h expected ffff/%h", mw_a[0], mw_d[0], exp_b[0]);
      end
      checks++;
      if (mw_a[1] !== 16'h0000 || mw_d[1] !== exp_b[1]) begin
        errors++; $display("FAIL wrap_second: got %h/%h expected 0000/%h", mw_a[1], mw_d[1], exp_b[1]);
      end
    end
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL wrap_ndone: got %0d expected 1", done_q.size()); end
  endtask

  task automatic test_len0();
    launch(16'($urandom), 16'd0, 4'h3, 30);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL len0_timeout: got 1 expected 0"); end
    checks++;
    if (mw_a.size() !== 0) begin errors++; $display("FAIL len0_writes: got %0d expected 0", mw_a.size()); end
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL len0_ndone: got %0d expected 1", done_q.size()); end
    if (done_q.size() > 0) begin
      checks++;
      if (done_q[0] !== 1 + 2 * PAGE_OVH) begin
        errors++; $display("FAIL len0_done_cycle: got %0d expected %0d", done_q[0], 1 + 2 * PAGE_OVH);
      end
    end
  endtask

  task automatic test_stall();
    fill(3);
    stall_armed = 1'b1; stall_at = 1;
    launch(16'h8000, 16'd3, 4'h0, 80);
    stall_armed = 1'b0;
    checks++;
    if (stall_hits !== 5) begin errors++; $display("FAIL stall_len: got %0d expected 5", stall_hits); end
    checks++;
    if (stall_bad !== 0) begin errors++; $display("FAIL stall_bus: got %0d bad cycles expected 0", stall_bad); end
    checks++;
    if (mw_a.size() !== 3 || consumed !== 3) begin
      errors++; $display("FAIL stall_nwrites: got %0d/%0d expected 3/3", mw_a.size(), consumed);
    end
    for (int i = 0; i < mw_a.size() && i < 3; i++) begin
      checks++;
      if (mw_a[i] !== 16'(16'h8000 + i) || mw_d[i] !== exp_b[i]) begin
        errors++; $display("FAIL stall_write[%0d]: got %h/%h expected %h/%h", i, mw_a[i], mw_d[i], 16'(16'h8000 + i), exp_b[i]);
      end
    end
    if (done_q.size() > 0) begin
      checks++;
      if (done_q[0] !== 15 + 2 * PAGE_OVH) begin
        errors++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_q[0], 15 + 2 * PAGE_OVH);
      end
    end
  endtask

  task automatic test_page();
    fill(1);
    launch(16'h6000, 16'd1, 4'h5, 60);
    checks++;
    if (mw_a.size() !== 1) begin errors++; $display("FAIL page_nwrites: got %0d expected 1", mw_a.size()); end
    if (mw_a.size() == 1) begin
      checks++;
      if (mw_a[0] !== 16'h6000 || mw_d[0] !== exp_b[0]) begin
        errors++; $display("FAIL page_data: got %h/%h expected 6000/%h", mw_a[0], mw_d[0], exp_b[0]);
      end
    end
`ifdef BUS_LOADER_DIVMMC_PAGE_EN
    checks++;
    if (ev_q.size() !== 3) begin errors++; $display("FAIL page_nevents: got %0d expected 3", ev_q.size()); end
    if (ev_q.size() == 3) begin
      checks++;
      if (ev_q[0] !== 0 || ev_q[1] !== 1 || ev_q[2] !== 0) begin
        errors++; $display("FAIL page_order: got %0d%0d%0d expected 010", ev_q[0], ev_q[1], ev_q[2]);
      end
    end
    if (io_a.size() == 2) begin
      checks++;
      if (io_a[0] !== 16'h00E3 || io_d[0] !== 8'h85) begin
        errors++; $display("FAIL page_in: got %h/%h expected 00e3/85", io_a[0], io_d[0]);
      end
      checks++;
      if (io_a[1] !== 16'h00E3 || io_d[1] !== 8'h00) begin
        errors++; $display("FAIL page_out: got %h/%h expected 00e3/00", io_a[1], io_d[1]);
      end
    end
    if (done_q.size() > 0) begin
      checks++;
      if (done_q[0] !== 8) begin errors++; $display("FAIL page_done_cycle: got %0d expected 8", done_q[0]); end
    end
`else
    checks++;
    if (io_a.size() !== 0 || ev_q.size() !== 1) begin
      errors++; $display("FAIL page_noio: got %0d io/%0d events expected 0/1", io_a.size(), ev_q.size());
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL page_invariants: got %0d expected 0", viol); end
`endif
  endtask

  task automatic test_reset_mid_write();
    bit hit;
    int dn;
    clear_log();
    fill(4);
    addr = 16'h1234; len = 16'd4; start = 1'b1; ce = 1'b1; svalid = 1'b1; sd = src_q[0];
    cycle();
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!mreq) begin hit = 1'b1; break; end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL rstw_reach_write: got 0 expected 1"); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mreq, wr, iorq, sready, busy, done} !== 6'b111000) begin
      errors++; $display("FAIL rstw_immediate: got %b expected 111000", {mreq, wr, iorq, sready, busy, done});
    end
    checks++;
    if (a !== 16'h0000 || d !== 8'h00) begin errors++; $display("FAIL rstw_bus: got %h/%h expected 0000/00", a, d); end
    src_q.delete();
    start = 1'b0; svalid = 1'b0;
    dn = 0;
    repeat (2) begin @(posedge clock); #1; if (done) dn++; end
    reset = 1'b1;
    clear_log();
    repeat (4) cycle();
    dn += done_q.size();
    checks++;
    if (dn !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_no_done: got %0d done busy=%b expected 0/0", dn, busy); end
    fill(2);
    launch(16'h2000, 16'd2, 4'h1, 60);
    checks++;
    if (mw_a.size() !== 2 || done_q.size() !== 1) begin
      errors++; $display("FAIL rstw_restart: got %0d writes %0d done expected 2/1", mw_a.size(), done_q.size());
    end
    if (mw_a.size() == 2) begin
      checks++;
      if (mw_a[1] !== 16'h2001 || mw_d[1] !== exp_b[1]) begin
        errors++; $display("FAIL rstw_restart_data: got %h/%h expected 2001/%h", mw_a[1], mw_d[1], exp_b[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a0;
    int n;
    ce_rand = 1; gap_rand = 1; start_noise = 1;
    for (int it = 0; it < 8; it++) begin
      a0 = (it % 3 == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
      n  = $urandom_range(0, 6);
      fill(n);
      launch(a0, 16'(n), 4'($urandom), 400);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: got 1 expected 0", it); end
      checks++;
      if (mw_a.size() !== n || consumed !== n) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes %0d consumed expected %0d", it, mw_a.size(), consumed, n);
      end
      for (int i = 0; i < mw_a.size() && i < n; i++) begin
        checks++;
        if (mw_a[i] !== 16'(a0 + i) || mw_d[i] !== exp_b[i]) begin
          errors++; $display("FAIL rand%0d_write[%0d]: got %h/%h expected %h/%h", it, i, mw_a[i], mw_d[i], 16'(a0 + i), exp_b[i]);
        end
      end
      checks++;
      if (done_q.size() !== 1 || viol !== 0 || io_a.size() !== IO_EXP) begin
        errors++; $display("FAIL rand%0d_misc: got done=%0d viol=%0d io=%0d expected 1/0/%0d", it, done_q.size(), viol, io_a.size(), IO_EXP);
      end
    end
    ce_rand = 0; gap_rand = 0; start_noise = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    ce_rand = 0; gap_rand = 0; start_noise = 0; stall_armed = 0; stall_at = 0;
    reset = 1'b0; ce = 1'b0; start = 1'b0; addr = 16'h0; len = 16'h0;
    page = 4'h0; sd = 8'h0; svalid = 1'b0;
    clear_log();
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_stall();
    test_page();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
